// File: rtl/fifo_serial_loopback.sv
// ---------------------------------------------------------------------------
// fifo_serial_loopback
//
// Byte-wide loopback channel for link bring-up. A transmit FIFO feeds a
// parallel-in/serial-out shifter (MSB first). The single-bit serial stream
// feeds a serial-in/parallel-out shifter. The reassembled word is queued in
// a receive FIFO. The block checks that buffering and serialisation
// round-trip data unchanged.
//
// Ports
//   clk      in   1      single clock, rising-edge state updates
//   rst      in   1      synchronous, active-low reset
//   write    in   1      push strobe shared by both FIFOs
//   read     in   1      pop strobe shared by both FIFOs
//   mod      in   1      shifter mode: 1 = load/hold, 0 = shift
//   datain   in   WIDTH  word pushed into the TX FIFO
//   dataout  out  WIDTH  registered word popped from the RX FIFO
// ---------------------------------------------------------------------------
module fifo_serial_loopback #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             write,
  input  logic             read,
  input  logic             mod,
  input  logic [WIDTH-1:0] datain,
  output logic [WIDTH-1:0] dataout
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL_C = CW'(DEPTH);
  localparam logic [CW-1:0] ONE_C  = CW'(1);
  localparam logic [AW-1:0] STEP_C = AW'(1);

  // TX FIFO state
  logic [WIDTH-1:0] tx_mem_r [DEPTH];
  logic [AW-1:0]    tx_wptr_r;
  logic [AW-1:0]    tx_rptr_r;
  logic [CW-1:0]    tx_count_r;
  logic [CW-1:0]    tx_count_nxt_s;
  logic [WIDTH-1:0] tx_word_r;
  logic             tx_full_s;
  logic             tx_empty_s;
  logic             tx_push_s;
  logic             tx_pop_s;

  // RX FIFO state
  logic [WIDTH-1:0] rx_mem_r [DEPTH];
  logic [AW-1:0]    rx_wptr_r;
  logic [AW-1:0]    rx_rptr_r;
  logic [CW-1:0]    rx_count_r;
  logic [CW-1:0]    rx_count_nxt_s;
  logic [WIDTH-1:0] dataout_r;
  logic             rx_full_s;
  logic             rx_empty_s;
  logic             rx_push_s;
  logic             rx_pop_s;

  // Shifters
  logic [WIDTH-1:0] psr_r;
  logic [WIDTH-1:0] ssr_r;
  logic             serial_s;
  logic [WIDTH-1:0] rx_word_s;

  assign serial_s  = psr_r[WIDTH-1];
  assign rx_word_s = ssr_r;
  assign dataout   = dataout_r;

  // A push into a full FIFO is allowed only when a pop frees a slot in the
  // same cycle; a pop from an empty FIFO never bypasses the incoming word.
  assign tx_full_s  = (tx_count_r == FULL_C);
  assign tx_empty_s = (tx_count_r == {CW{1'b0}});
  assign tx_pop_s   = read & ~tx_empty_s;
  assign tx_push_s  = write & (~tx_full_s | tx_pop_s);

  assign rx_full_s  = (rx_count_r == FULL_C);
  assign rx_empty_s = (rx_count_r == {CW{1'b0}});
  assign rx_pop_s   = read & ~rx_empty_s;
  assign rx_push_s  = write & (~rx_full_s | rx_pop_s);

  // TX occupancy next-state
  always_comb begin
    tx_count_nxt_s = tx_count_r;
    case ({tx_push_s, tx_pop_s})
      2'b10:   tx_count_nxt_s = tx_count_r + ONE_C;
      2'b01:   tx_count_nxt_s = tx_count_r - ONE_C;
      default: tx_count_nxt_s = tx_count_r;
    endcase
  end

  // RX occupancy next-state
  always_comb begin
    rx_count_nxt_s = rx_count_r;
    case ({rx_push_s, rx_pop_s})
      2'b10:   rx_count_nxt_s = rx_count_r + ONE_C;
      2'b01:   rx_count_nxt_s = rx_count_r - ONE_C;
      default: rx_count_nxt_s = rx_count_r;
    endcase
  end

  // TX storage write (contents need no reset; pointers gate visibility)
  always_ff @(posedge clk) begin
    if (rst && tx_push_s) begin
      tx_mem_r[tx_wptr_r] <= datain;
    end
  end

  // RX storage write
  always_ff @(posedge clk) begin
    if (rst && rx_push_s) begin
      rx_mem_r[rx_wptr_r] <= rx_word_s;
    end
  end

  // TX pointers, occupancy and registered head output
  always_ff @(posedge clk) begin
    if (!rst) begin
      tx_wptr_r  <= {AW{1'b0}};
      tx_rptr_r  <= {AW{1'b0}};
      tx_count_r <= {CW{1'b0}};
      tx_word_r  <= {WIDTH{1'b0}};
    end else begin
      if (tx_push_s) begin
        tx_wptr_r <= tx_wptr_r + STEP_C;
      end
      if (tx_pop_s) begin
        tx_rptr_r <= tx_rptr_r + STEP_C;
        tx_word_r <= tx_mem_r[tx_rptr_r];
      end
      tx_count_r <= tx_count_nxt_s;
    end
  end

  // RX pointers, occupancy and registered dataout
  always_ff @(posedge clk) begin
    if (!rst) begin
      rx_wptr_r  <= {AW{1'b0}};
      rx_rptr_r  <= {AW{1'b0}};
      rx_count_r <= {CW{1'b0}};
      dataout_r  <= {WIDTH{1'b0}};
    end else begin
      if (rx_push_s) begin
        rx_wptr_r <= rx_wptr_r + STEP_C;
      end
      if (rx_pop_s) begin
        rx_rptr_r <= rx_rptr_r + STEP_C;
        dataout_r <= rx_mem_r[rx_rptr_r];
      end
      rx_count_r <= rx_count_nxt_s;
    end
  end

  // PISO/SIPO pair: load on mod=1 (SIPO holds), shift MSB first on mod=0
  always_ff @(posedge clk) begin
    if (!rst) begin
      psr_r <= {WIDTH{1'b0}};
      ssr_r <= {WIDTH{1'b0}};
    end else if (mod) begin
      psr_r <= tx_word_r;
    end else begin
      psr_r <= {psr_r[WIDTH-2:0], 1'b0};
      ssr_r <= {ssr_r[WIDTH-2:0], serial_s};
    end
  end

endmodule

// File: tb/tb_fifo_serial_loopback.sv
// ---------------------------------------------------------------------------
// tb_fifo_serial_loopback
//
// Directed bench for fifo_serial_loopback. Inputs change 1 time unit after
// each rising edge; outputs and internal registers are observed at that same
// point, i.e. after the edge has settled.
// ---------------------------------------------------------------------------
module tb_fifo_serial_loopback;

  logic       clk;
  logic       rst;
  logic       write;
  logic       read;
  logic       mod;
  logic [7:0] datain;
  logic [7:0] dataout;

  int n_cmp;
  int n_bad;

  fifo_serial_loopback #(.DEPTH(8), .WIDTH(8)) dut (
    .clk     (clk),
    .rst     (rst),
    .write   (write),
    .read    (read),
    .mod     (mod),
    .datain  (datain),
    .dataout (dataout)
  );

  // 10-unit clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp = n_cmp + 1;
    if (obs !== exp) begin
      n_bad = n_bad + 1;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Apply one cycle of strobes, then settle past the edge
  task automatic cyc(input logic w, input logic r, input logic m, input logic [7:0] d);
    write  = w;
    read   = r;
    mod    = m;
    datain = d;
    @(posedge clk);
    #1;
  endtask

  // One-cycle reset with idle strobes
  task automatic do_reset();
    rst = 1'b0;
    cyc(1'b0, 1'b0, 1'b1, 8'h00);
    rst = 1'b1;
  endtask

  // Full loopback of one byte through both FIFOs and the shifters
  task automatic loopback(input logic [7:0] b, input string tag);
    cyc(1'b1, 1'b0, 1'b1, b);
    cyc(1'b0, 1'b1, 1'b1, 8'h00);
    chk({tag, "_txword"}, {24'h0, dut.tx_word_r}, {24'h0, b});
    chk({tag, "_dout_pre"}, {24'h0, dataout}, 32'h0000_0000);
    cyc(1'b0, 1'b0, 1'b1, 8'h00);
    for (int i = 0; i < 8; i++) cyc(1'b0, 1'b0, 1'b0, 8'h00);
    chk({tag, "_ssr"}, {24'h0, dut.ssr_r}, {24'h0, b});
    cyc(1'b1, 1'b0, 1'b1, 8'h00);
    cyc(1'b0, 1'b1, 1'b1, 8'h00);
    chk({tag, "_dout"}, {24'h0, dataout}, {24'h0, b});
  endtask

  initial begin
    logic [7:0] exp_b;
    n_cmp  = 0;
    n_bad  = 0;
    rst    = 1'b0;
    write  = 1'b0;
    read   = 1'b0;
    mod    = 1'b1;
    datain = 8'h00;

    // Reset held with both strobes active
    rst = 1'b0;
    cyc(1'b1, 1'b1, 1'b1, 8'h55);
    cyc(1'b1, 1'b1, 1'b1, 8'h55);
    chk("rst_dout", {24'h0, dataout}, 32'h0000_0000);
    chk("rst_txword", {24'h0, dut.tx_word_r}, 32'h0000_0000);
    chk("rst_txcnt", 32'(dut.tx_count_r), 32'd0);
    chk("rst_rxcnt", 32'(dut.rx_count_r), 32'd0);
    chk("rst_ssr", {24'h0, dut.ssr_r}, 32'h0000_0000);
    rst = 1'b1;
    cyc(1'b0, 1'b1, 1'b1, 8'h00);
    chk("rst_read_empty", {24'h0, dataout}, 32'h0000_0000);

    // Loopback of 0x12
    do_reset();
    loopback(8'h12, "lb12");

    // Bit order: 0x80 walks across the SIPO one place per shift
    do_reset();
    cyc(1'b1, 1'b0, 1'b1, 8'h80);
    cyc(1'b0, 1'b1, 1'b1, 8'h00);
    cyc(1'b0, 1'b0, 1'b1, 8'h00);
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 1'b0, 8'h00);
    chk("bo_ssr4", {24'h0, dut.ssr_r}, 32'h0000_0008);
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 1'b0, 8'h00);
    chk("bo_ssr8", {24'h0, dut.ssr_r}, 32'h0000_0080);
    cyc(1'b0, 1'b0, 1'b0, 8'h00);
    chk("bo_ssr9", {24'h0, dut.ssr_r}, 32'h0000_0000);

    // TX full: ninth write dropped
    do_reset();
    for (int i = 1; i <= 9; i++) cyc(1'b1, 1'b0, 1'b1, 8'(i));
    chk("full_txcnt", 32'(dut.tx_count_r), 32'd8);
    for (int i = 1; i <= 9; i++) begin
      exp_b = (i > 8) ? 8'h08 : 8'(i);
      cyc(1'b0, 1'b1, 1'b1, 8'h00);
      chk($sformatf("full_rd%0d", i), {24'h0, dut.tx_word_r}, {24'h0, exp_b});
    end
    chk("full_txcnt_end", 32'(dut.tx_count_r), 32'd0);

    // Simultaneous strobes on empty FIFOs: push only, no bypass
    do_reset();
    cyc(1'b1, 1'b1, 1'b1, 8'h77);
    chk("se_txword", {24'h0, dut.tx_word_r}, 32'h0000_0000);
    chk("se_dout", {24'h0, dataout}, 32'h0000_0000);
    chk("se_txcnt", 32'(dut.tx_count_r), 32'd1);
    chk("se_rxcnt", 32'(dut.rx_count_r), 32'd1);

    // Simultaneous strobes on a full FIFO: pop head and store new word
    do_reset();
    for (int i = 0; i < 8; i++) cyc(1'b1, 1'b0, 1'b1, 8'(8'h11 + i));
    cyc(1'b1, 1'b1, 1'b1, 8'h99);
    chk("sf_txword", {24'h0, dut.tx_word_r}, 32'h0000_0011);
    chk("sf_txcnt", 32'(dut.tx_count_r), 32'd8);
    for (int i = 0; i < 8; i++) begin
      exp_b = (i == 7) ? 8'h99 : 8'(8'h12 + i);
      cyc(1'b0, 1'b1, 1'b1, 8'h00);
      chk($sformatf("sf_rd%0d", i), {24'h0, dut.tx_word_r}, {24'h0, exp_b});
    end

    // Reset mid-shift discards the partial 0xA5
    do_reset();
    cyc(1'b1, 1'b0, 1'b1, 8'hA5);
    cyc(1'b0, 1'b1, 1'b1, 8'h00);
    cyc(1'b0, 1'b0, 1'b1, 8'h00);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b0, 8'h00);
    chk("ms_partial", {24'h0, dut.ssr_r}, 32'h0000_0005);
    do_reset();
    chk("ms_ssr_clr", {24'h0, dut.ssr_r}, 32'h0000_0000);
    chk("ms_psr_clr", {24'h0, dut.psr_r}, 32'h0000_0000);
    loopback(8'h3C, "lb3c");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fifo_serial_loopback.md
# fifo_serial_loopback

Byte-wide loopback channel for link bring-up: a transmit FIFO feeds a parallel-in/serial-out shifter, the single-bit serial stream feeds a serial-in/parallel-out shifter, and the reassembled byte is queued in a receive FIFO. It sits between a host byte interface and itself, checking that FIFO buffering and MSB-first serialisation round-trip data unchanged.

## Interface
- DEPTH, 8, entries per FIFO; power of two, at least 2.
- WIDTH, 8, data word width and shift-register length.
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  reset; synchronous and active-low.
- write  input  1  push strobe, shared by both FIFOs.
- read  input  1  pop strobe, shared by both FIFOs.
- mod  input  1  shifter mode: 1 = load/hold, 0 = shift.
- datain  input  WIDTH  word pushed into the TX FIFO.
- dataout  output  WIDTH  registered word popped from the RX FIFO.

## Operation
- Datapath: datain -> TX FIFO -> tx_word -> PISO -> serial bit -> SIPO -> rx_word -> RX FIFO -> dataout.
- FIFO, used for both instances:
  - Circular buffer with write pointer, read pointer, and count (0..DEPTH). Internal full is count==DEPTH; internal empty is count==0.
  - Push stores the input word when write=1 and the FIFO is not full. A push while full is dropped with no state change.
  - Pop loads the head entry into the registered output when read=1 and the FIFO is not empty. A pop while empty leaves the output unchanged.
  - write=1 and read=1 together:
    - Both operations proceed, and count is unchanged.
    - When empty, only the push happens. There is no bypass to the output.
    - When full, both happen. The pop frees the slot used by the push.
  - Pointers wrap modulo DEPTH.
  - The output holds its last popped value indefinitely.
- TX FIFO input is datain; its output is tx_word.
- RX FIFO input is rx_word; its output is dataout.
- PISO has a WIDTH-bit register psr; serial = psr[WIDTH-1].
  - mod=1: psr <= tx_word (parallel load).
  - mod=0: psr <= {psr[WIDTH-2:0], 1'b0}. Shifts out MSB first and fills with zeros.
- SIPO has a WIDTH-bit register ssr; rx_word = ssr.
  - mod=0: ssr <= {ssr[WIDTH-2:0], serial}.
  - mod=1: ssr holds.
- Round trip: one mod=1 cycle followed by exactly WIDTH mod=0 cycles leaves rx_word equal to the loaded tx_word.
  - More shifts move zeros in.
  - Fewer shifts leave a partial word.

## Timing
- Reset (rst=0 at a rising edge) clears both FIFOs (pointers and count to 0), tx_word, psr, ssr, and dataout to 0.
- Reset overrides all strobes in the same cycle. Reset asserted mid-shift discards the partial word.
- Push latency: a word written at edge N is poppable from edge N+1.
- Pop latency: dataout (or tx_word) updates at the edge where read=1 is sampled, and is visible after that edge.
- PISO load: psr takes tx_word at the edge where mod=1 is sampled, so the tx_word value must already be valid before that edge.
- Shift cadence: one bit per clock while mod=0. The first shifted bit is the one present on serial before the edge.
- RX push of rx_word happens at any edge with write=1. Sequencing write relative to the shift window is the user's responsibility.
- Shared strobes: each write/read affects both FIFOs in the same cycle, each subject to its own full/empty state.

## Test plan
- Reset:
  - Stimulus: hold rst=0 for 2 cycles with write=read=1.
  - Required: dataout=0x00; after release, read alone leaves dataout=0x00 (RX FIFO empty).
- Loopback of 0x12:
  - Stimulus, in order:
    1. Write with datain=0x12 for 1 cycle.
    2. Read for 1 cycle; tx_word=0x12, dataout stays 0x00.
    3. mod=1 for 1 cycle, then mod=0 for 8 cycles.
    4. write=1 for 1 cycle.
    5. read=1 for 1 cycle.
  - Required: dataout=0x12.
- Bit order:
  - Stimulus: load 0x80 and shift 4 cycles.
  - Required: ssr=0x08; after 4 more shifts ssr=0x80; after a 9th shift ssr=0x00.
- TX full:
  - Stimulus: 9 consecutive writes of 0x01..0x09, then 9 reads.
  - Required: tx_word steps 0x01..0x08; the 9th read leaves tx_word=0x08 (0x09 was dropped).
- Simultaneous strobes:
  - Stimulus: write=read=1 with both FIFOs empty.
  - Required: outputs unchanged and count becomes 1.
  - Stimulus: write=read=1 with a FIFO full.
  - Required: the head is popped, the new word is stored, and count stays DEPTH.
- Reset mid-shift:
  - Stimulus: assert rst=0 after 3 of 8 shifts of 0xA5, then repeat the loopback sequence with 0x3C.
  - Required: dataout=0x3C with no residue from 0xA5.
